// File: rtl/fetch.sv
// Instruction fetch unit: reads one or two 16-bit words per instruction over a
// req/ack memory port, issues them to decode, and steps the PC on retire.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          EXT_BIT  = 15
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ins,
  output logic [15:0] ext,
  output logic        ins_en,
  input  logic        retire,
  input  logic        set_pc,
  input  logic        add_pc,
  input  logic        inc_pc,
  input  logic [15:0] pc_val,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    START,
    REQ_INS,
    REQ_EXT,
    ISSUE,
    WAIT_RET
  } state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic [15:0] mem_addr_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] seq_pc;
  logic [15:0] ins_q;
  logic [15:0] ins_buf_q;
  logic [15:0] ext_q;
  logic        ins_en_q;

  // The sequential successor skips the extension word of the current instruction.
  assign seq_pc = pc_q + 16'd1 + {15'd0, ins_q[EXT_BIT]};

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    pc_d = seq_pc;
    if (set_pc)      pc_d = pc_val;
    else if (add_pc) pc_d = pc_q + pc_val;
    else if (inc_pc) pc_d = seq_pc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      state_q    <= START;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      ins_q      <= 16'h0000;
      ins_buf_q  <= 16'h0000;
      ext_q      <= 16'h0000;
      ins_en_q   <= 1'b0;
    end else begin
      ins_en_q <= 1'b0;
      case (state_q)
        START: begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc_q;
          state_q    <= REQ_INS;
        end
        REQ_INS: begin
          if (mem_ack) begin
            if (mem_rdata[EXT_BIT]) begin
              // Hold the first word aside so ins stays stable until ISSUE.
              ins_buf_q  <= mem_rdata;
              mem_addr_q <= pc_q + 16'd1;
              state_q    <= REQ_EXT;
            end else begin
              ins_q     <= mem_rdata;
              ext_q     <= 16'h0000;
              mem_req_q <= 1'b0;
              ins_en_q  <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        REQ_EXT: begin
          if (mem_ack) begin
            ins_q     <= ins_buf_q;
            ext_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            ins_en_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE, WAIT_RET: begin
          if (retire) begin
            pc_q       <= pc_d;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_d;
            state_q    <= REQ_INS;
          end else begin
            state_q <= WAIT_RET;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ins      = ins_q;
  assign ext      = ext_q;
  assign ins_en   = ins_en_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a wait-state memory responder plus a queue of
// expected {ins, ext, pc} issues popped whenever ins_en fires.
module tb_fetch;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ins;
  logic [15:0] ext;
  logic        ins_en;
  logic        retire;
  logic        set_pc;
  logic        add_pc;
  logic        inc_pc;
  logic [15:0] pc_val;
  logic [15:0] pc;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] ext;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] addr_log[$];
  logic [15:0] mem[0:65535];
  int          wait_cfg;
  bit          stray_en;
  int          checks;
  int          errors;

  fetch #(.RESET_PC(16'h0000), .EXT_BIT(15)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ins      (ins),
    .ext      (ext),
    .ins_en   (ins_en),
    .retire   (retire),
    .set_pc   (set_pc),
    .add_pc   (add_pc),
    .inc_pc   (inc_pc),
    .pc_val   (pc_val),
    .pc       (pc)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: wait_cfg wait cycles per request, request must stay
  // stable while pending, optional stray acks while no request is open.
  initial begin
    bit          busy;
    int          left;
    logic [15:0] held;
    busy      = 1'b0;
    left      = 0;
    held      = 16'h0000;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge cpu_clk);
      #1;
      mem_ack = 1'b0;
      if (!cpu_rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          check("req_hold", {15'd0, mem_req}, 16'd1);
          check("addr_hold", mem_addr, held);
        end else if (mem_req) begin
          busy = 1'b1;
          held = mem_addr;
          left = wait_cfg;
        end
        if (busy) begin
          if (left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[held];
            addr_log.push_back(held);
            busy      = 1'b0;
          end else begin
            left--;
          end
        end else if (stray_en && !mem_req) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'hFFFF;
        end
      end
    end
  end

  task automatic push(input logic [15:0] i, input logic [15:0] e, input logic [15:0] p);
    exp_t x;
    x.ins = i;
    x.ext = e;
    x.pc  = p;
    sb.push_back(x);
  endtask

  // Called on the negedge where ins_en is high, so retire lands in ISSUE.
  task automatic do_retire(input logic s, input logic a, input logic i, input logic [15:0] v);
    set_pc = s;
    add_pc = a;
    inc_pc = i;
    pc_val = v;
    retire = 1'b1;
    @(negedge cpu_clk);
    retire = 1'b0;
    set_pc = 1'b0;
    add_pc = 1'b0;
    inc_pc = 1'b0;
  endtask

  // lat: required cycles from retire to ins_en (0 = not checked).
  task automatic expect_issue(input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (ins_en !== 1'b1 && n < 100) begin
      @(negedge cpu_clk);
      n++;
    end
    check("ins_en_seen", {15'd0, ins_en}, 16'd1);
    if (lat > 0) check("latency", 16'(n + 1), 16'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ins", ins, e.ins);
      check("ext", ext, e.ext);
      check("pc", pc, e.pc);
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    cpu_rst  = 1'b0;
    retire   = 1'b0;
    set_pc   = 1'b0;
    add_pc   = 1'b0;
    inc_pc   = 1'b0;
    pc_val   = 16'h0000;
    wait_cfg = 0;
    stray_en = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check("rst_mem_req", {15'd0, mem_req}, 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_ins", ins, 16'h0000);
    check("rst_ext", ext, 16'h0000);
    check("rst_ins_en", {15'd0, ins_en}, 16'd0);

    // Sequential one-word instructions
    mem[16'h0000] = 16'h0123;
    mem[16'h0001] = 16'h0456;
    push(16'h0123, 16'h0000, 16'h0000);
    cpu_rst = 1'b1;
    expect_issue(0);
    push(16'h0456, 16'h0000, 16'h0001);
    do_retire(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_issue(2);

    // Extension word
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    mem[16'h0000] = 16'h8001;
    mem[16'h0001] = 16'hBEEF;
    mem[16'h0002] = 16'h0007;
    push(16'h8001, 16'hBEEF, 16'h0000);
    cpu_rst = 1'b1;
    expect_issue(0);
    push(16'h0007, 16'h0000, 16'h0002);
    do_retire(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_issue(2);
    push(16'h8001, 16'hBEEF, 16'h0000);
    do_retire(1'b1, 1'b0, 1'b0, 16'h0000);
    expect_issue(3);

    // Jump: set_pc beats add_pc
    mem[16'h1234] = 16'h0042;
    push(16'h0042, 16'h0000, 16'h1234);
    do_retire(1'b1, 1'b1, 1'b0, 16'h1234);
    check("jump_req", {15'd0, mem_req}, 16'd1);
    check("jump_addr", mem_addr, 16'h1234);
    check("jump_pc", pc, 16'h1234);
    expect_issue(2);

    // Relative branch with wrap
    push(16'h0007, 16'h0000, 16'h0002);
    do_retire(1'b1, 1'b0, 1'b0, 16'h0002);
    expect_issue(2);
    mem[16'hFFFE] = 16'h0011;
    push(16'h0011, 16'h0000, 16'hFFFE);
    do_retire(1'b0, 1'b1, 1'b0, 16'hFFFC);
    expect_issue(2);

    // Extension fetch wraps to address 0
    mem[16'hFFFF] = 16'h8000;
    push(16'h8000, 16'h8001, 16'hFFFF);
    addr_log.delete();
    do_retire(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_issue(3);
    check("log_size", 16'(addr_log.size()), 16'd2);
    if (addr_log.size() >= 2) begin
      check("ins_addr", addr_log[0], 16'hFFFF);
      check("ext_addr", addr_log[1], 16'h0000);
    end
    push(16'hBEEF, 16'h0007, 16'h0001);
    do_retire(1'b0, 1'b0, 1'b1, 16'h0000);
    expect_issue(3);

    // Three wait states per access
    wait_cfg = 3;
    mem[16'h0100] = 16'h0200;
    push(16'h0200, 16'h0000, 16'h0100);
    do_retire(1'b1, 1'b0, 1'b0, 16'h0100);
    expect_issue(5);

    // Reset while the extension word is pending
    mem[16'h0300] = 16'h8000;
    mem[16'h0301] = 16'h1111;
    do_retire(1'b1, 1'b0, 1'b0, 16'h0300);
    n = 0;
    while (mem_addr !== 16'h0301 && n < 20) begin
      @(negedge cpu_clk);
      n++;
    end
    check("reach_req_ext", mem_addr, 16'h0301);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check("mid_rst_req", {15'd0, mem_req}, 16'd0);
    check("mid_rst_ins_en", {15'd0, ins_en}, 16'd0);
    check("mid_rst_pc", pc, 16'h0000);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_ins", ins, 16'h0000);
    sb.delete();
    stray_en = 1'b1;
    push(16'h8001, 16'hBEEF, 16'h0000);
    cpu_rst = 1'b1;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge cpu_clk);
      n++;
    end
    check("refetch_addr", mem_addr, 16'h0000);
    expect_issue(0);

    // Stray acks while parked in WAIT_RET
    repeat (3) @(negedge cpu_clk);
    check("stray_ins_en", {15'd0, ins_en}, 16'd0);
    check("stray_req", {15'd0, mem_req}, 16'd0);
    check("stray_ins", ins, 16'h8001);
    check("stray_pc", pc, 16'h0000);
    stray_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
